// File: rtl/debug_slave_scan_engine_if.sv
// Signal bundle between the virtual-JTAG front end / command consumer and the
// debug-slave scan engine.
interface debug_slave_scan_engine_if #(
    parameter int IR_W       = 2,
    parameter int DR_W       = 38,
    parameter int RD_W       = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int N_CH  = 2**IR_W;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                 vs_uir;
    logic                 vs_cdr;
    logic                 vs_sdr;
    logic                 vs_udr;
    logic                 shift_en;
    logic                 tdi;
    logic [IR_W-1:0]      ir_in;
    logic [N_CH*RD_W-1:0] rd_data;
    logic                 cmd_ready;

    logic                 tdo;
    logic [IR_W-1:0]      ir_q;
    logic [DR_W-1:0]      jdo;
    logic [IR_W-1:0]      jdo_ir;
    logic [N_CH-1:0]      take_action;
    logic [N_CH-1:0]      take_no_action;
    logic [LVL_W-1:0]     fifo_level;
    logic                 ovf_flag;
    logic                 short_flag;

    modport master (
        output vs_uir, vs_cdr, vs_sdr, vs_udr, shift_en, tdi, ir_in, rd_data, cmd_ready,
        input  tdo, ir_q, jdo, jdo_ir, take_action, take_no_action, fifo_level,
               ovf_flag, short_flag
    );

    modport slave (
        input  vs_uir, vs_cdr, vs_sdr, vs_udr, shift_en, tdi, ir_in, rd_data, cmd_ready,
        output tdo, ir_q, jdo, jdo_ir, take_action, take_no_action, fifo_level,
               ovf_flag, short_flag
    );
endinterface

// File: rtl/debug_slave_scan_engine.sv
// Debug-slave scan engine: IR/DR scan FSM feeding a command queue that drains
// as one-hot take_action / take_no_action pulses with the payload on jdo.
module debug_slave_scan_engine #(
    parameter int IR_W       = 2,
    parameter int DR_W       = 38,
    parameter int RD_W       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    debug_slave_scan_engine_if.slave bus
);
    localparam int N_CH  = 2**IR_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DR_W + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DR_W + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] dr;
    } cmd_t;

    state_t           state_q, state_d;
    logic [DR_W-1:0]  sr;
    logic [IR_W-1:0]  ir_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             ovf_flag, short_flag;

    cmd_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;

    logic [DR_W-1:0]  jdo;
    logic [IR_W-1:0]  jdo_ir;
    logic [N_CH-1:0]  take_action, take_no_action;

    logic             do_uir, do_cdr, do_shift, do_udr;
    logic             push, pop, set_ovf, set_short;
    logic [RD_W-1:0]  rd_word;
    logic [DR_W-1:0]  cap_word;
    cmd_t             head;
    logic [N_CH-1:0]  head_onehot;

    // NOTE: every signal written here is given a default first, so no path
    // through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        do_uir      = bus.vs_uir;
        do_cdr      = !bus.vs_uir && bus.vs_cdr;
        do_shift    = !bus.vs_uir && !bus.vs_cdr && (state_q == SHIFT)
                      && bus.vs_sdr && bus.shift_en;
        do_udr      = !bus.vs_uir && !bus.vs_cdr && !do_shift
                      && (state_q == SHIFT) && bus.vs_udr;

        // A full-length scan that finds the queue full is dropped, even if a
        // pop frees a slot in the same cycle.
        push        = do_udr && (bit_cnt == CNT_FULL) && (level != LVL_FULL);
        set_ovf     = do_udr && (bit_cnt == CNT_FULL) && (level == LVL_FULL);
        set_short   = do_udr && (bit_cnt != CNT_FULL);
        pop         = (level != '0) && bus.cmd_ready;

        rd_word = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ir_q == IR_W'(k)) rd_word = bus.rd_data[k*RD_W +: RD_W];
        end

        cap_word           = '0;
        cap_word[RD_W-1:0] = rd_word;
        cap_word[DR_W-1]   = ovf_flag;
        cap_word[DR_W-2]   = short_flag;

        head        = mem[rd_ptr];
        head_onehot = N_CH'(1) << head.ir;

        state_d = state_q;
        if (state_q == UPDATE) state_d = IDLE;
        if (do_udr)            state_d = UPDATE;
        if (do_cdr)            state_d = SHIFT;
        if (do_uir)            state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            sr             <= '0;
            ir_q           <= '0;
            bit_cnt        <= '0;
            ovf_flag       <= 1'b0;
            short_flag     <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            jdo            <= '0;
            jdo_ir         <= '0;
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            state_q <= state_d;

            if (do_uir) ir_q <= bus.ir_in;

            if (do_cdr) begin
                sr      <= cap_word;
                bit_cnt <= '0;
            end else if (do_shift) begin
                sr <= {bus.tdi, sr[DR_W-1:1]};
                if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
            end

            // Read-to-clear on capture; a set in the same cycle takes priority.
            ovf_flag   <= (ovf_flag   && !do_cdr) || set_ovf;
            short_flag <= (short_flag && !do_cdr) || set_short;

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase

            take_action    <= '0;
            take_no_action <= '0;
            if (pop) begin
                jdo    <= head.dr;
                jdo_ir <= head.ir;
                if (head.dr[DR_W-1]) take_action    <= head_onehot;
                else                 take_no_action <= head_onehot;
            end
        end
    end

    // NOTE: queue storage is deliberately not reset; an entry is only ever
    // read after it has been written, and the pointers/level are reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{ir: ir_q, dr: sr};
    end

    assign bus.tdo            = sr[0];
    assign bus.ir_q           = ir_q;
    assign bus.jdo            = jdo;
    assign bus.jdo_ir         = jdo_ir;
    assign bus.take_action    = take_action;
    assign bus.take_no_action = take_no_action;
    assign bus.fifo_level     = level;
    assign bus.ovf_flag       = ovf_flag;
    assign bus.short_flag     = short_flag;

endmodule

// File: tb/tb_debug_slave_scan_engine.sv
// Bench for debug_slave_scan_engine: directed scenarios plus randomized scans,
// all compared each cycle against a queue-based reference model.
module tb_debug_slave_scan_engine;
    localparam int IR_W       = 2;
    localparam int DR_W       = 38;
    localparam int RD_W       = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int N_CH       = 2**IR_W;

    typedef struct {
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] dr;
    } cmd_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    debug_slave_scan_engine_if #(
        .IR_W(IR_W), .DR_W(DR_W), .RD_W(RD_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) bus ();

    debug_slave_scan_engine #(
        .IR_W(IR_W), .DR_W(DR_W), .RD_W(RD_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;   // 0: cmd_ready low, 1: high, 2: random per cycle

    logic [RD_W-1:0] rd [N_CH];

    // Reference model state
    logic [IR_W-1:0] m_ir;
    logic [DR_W-1:0] m_sr;
    int              m_cnt;
    bit              m_in_scan;
    bit              m_ovf, m_short;
    cmd_t            q [$];
    logic [DR_W-1:0] m_jdo;
    logic [IR_W-1:0] m_jdo_ir;
    logic [N_CH-1:0] m_ta, m_tna;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ir = '0; m_sr = '0; m_cnt = 0; m_in_scan = 0;
        m_ovf = 0; m_short = 0; q.delete();
        m_jdo = '0; m_jdo_ir = '0; m_ta = '0; m_tna = '0;
    endtask

    // Apply current inputs for one clock, advance the model, compare outputs.
    task automatic cycle();
        cmd_t c;
        int   size0;
        if (ready_mode == 2) bus.cmd_ready = 1'($urandom_range(0, 1));
        else                 bus.cmd_ready = (ready_mode == 1);
        for (int k = 0; k < N_CH; k++) bus.rd_data[k*RD_W +: RD_W] = rd[k];

        m_ta = '0;
        m_tna = '0;
        if (reset) begin
            model_reset();
        end else begin
            size0 = q.size();
            if (size0 != 0 && bus.cmd_ready) begin
                c = q.pop_front();
                m_jdo = c.dr;
                m_jdo_ir = c.ir;
                if (c.dr[DR_W-1]) m_ta[c.ir] = 1'b1;
                else              m_tna[c.ir] = 1'b1;
            end
            if (bus.vs_uir) begin
                m_ir = bus.ir_in;
                m_in_scan = 0;
            end else if (bus.vs_cdr) begin
                m_sr = '0;
                m_sr[RD_W-1:0] = rd[m_ir];
                m_sr[DR_W-1] = m_ovf;
                m_sr[DR_W-2] = m_short;
                m_cnt = 0;
                m_ovf = 0;
                m_short = 0;
                m_in_scan = 1;
            end else if (m_in_scan && bus.vs_sdr && bus.shift_en) begin
                m_sr = (m_sr >> 1) | (DR_W'(bus.tdi) << (DR_W - 1));
                if (m_cnt < DR_W + 1) m_cnt++;
            end else if (m_in_scan && bus.vs_udr) begin
                if (m_cnt != DR_W)            m_short = 1;
                else if (size0 == FIFO_DEPTH) m_ovf = 1;
                else                          q.push_back('{ir: m_ir, dr: m_sr});
                m_in_scan = 0;
            end
        end

        @(posedge clk);
        #1;
        check("tdo",            64'(bus.tdo),            64'(m_sr[0]));
        check("ir_q",           64'(bus.ir_q),           64'(m_ir));
        check("jdo",            64'(bus.jdo),            64'(m_jdo));
        check("jdo_ir",         64'(bus.jdo_ir),         64'(m_jdo_ir));
        check("take_action",    64'(bus.take_action),    64'(m_ta));
        check("take_no_action", 64'(bus.take_no_action), 64'(m_tna));
        check("fifo_level",     64'(bus.fifo_level),     64'(q.size()));
        check("ovf_flag",       64'(bus.ovf_flag),       64'(m_ovf));
        check("short_flag",     64'(bus.short_flag),     64'(m_short));
    endtask

    task automatic set_ir(input logic [IR_W-1:0] v);
        bus.vs_uir = 1'b1;
        bus.ir_in  = v;
        cycle();
        bus.vs_uir = 1'b0;
    endtask

    task automatic capture();
        bus.vs_cdr = 1'b1;
        cycle();
        bus.vs_cdr = 1'b0;
    endtask

    // Shift n bits of data LSB-first; tv collects tdo as seen before each shift.
    task automatic shift_bits(input logic [63:0] data, input int n, input bit gaps,
                              output logic [63:0] tv);
        int i = 0;
        tv = '0;
        while (i < n) begin
            bus.vs_sdr = 1'b1;
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.shift_en = 1'b0;
                cycle();
            end else begin
                tv[i] = bus.tdo;
                bus.shift_en = 1'b1;
                bus.tdi = data[i];
                cycle();
                i++;
            end
        end
        bus.vs_sdr = 1'b0;
        bus.shift_en = 1'b0;
        bus.tdi = 1'b0;
    endtask

    task automatic update();
        bus.vs_udr = 1'b1;
        cycle();
        bus.vs_udr = 1'b0;
    endtask

    task automatic full_scan(input logic [63:0] data);
        logic [63:0] tv;
        capture();
        shift_bits(data, DR_W, 1'b0, tv);
        update();
    endtask

    initial begin
        logic [63:0] tv;
        logic [63:0] data;
        int n;

        reset = 1'b1;
        bus.vs_uir = 0; bus.vs_cdr = 0; bus.vs_sdr = 0; bus.vs_udr = 0;
        bus.shift_en = 0; bus.tdi = 0; bus.ir_in = '0; bus.cmd_ready = 0;
        bus.rd_data = '0;
        for (int k = 0; k < N_CH; k++) rd[k] = RD_W'(32'h1111_1111 * (k + 1));
        model_reset();

        cycle();
        cycle();
        check("reset_level", 64'(bus.fifo_level), 64'(0));
        check("reset_jdo",   64'(bus.jdo),        64'(0));
        reset = 1'b0;
        cycle();

        // Readback capture of channel 2, shifted out LSB-first
        ready_mode = 1;
        rd[2] = 32'hDEADBEEF;
        set_ir(2);
        capture();
        shift_bits(64'(0), DR_W, 1'b0, tv);
        check("rd_bytes",   tv[31:0],  64'h0000_0000_DEAD_BEEF);
        check("rd_topbits", tv[37:32], 64'(0));

        // Action scan on channel 1
        set_ir(1);
        capture();
        shift_bits(64'h20_0000_0123, DR_W, 1'b0, tv);
        update();
        check("act_early", 64'(bus.take_action), 64'(0));
        bus.vs_udr = 1'b0;
        cycle();
        check("act_pulse",  64'(bus.take_action), 64'h2);
        check("act_jdo",    64'(bus.jdo),         64'h20_0000_0123);
        check("act_jdo_ir", 64'(bus.jdo_ir),      64'(1));
        cycle();
        check("act_one_cycle", 64'(bus.take_action), 64'(0));

        // No-action scan on channel 3
        set_ir(3);
        full_scan(64'h00_0000_0123);
        cycle();
        check("noact_pulse", 64'(bus.take_no_action), 64'h8);
        check("noact_ta",    64'(bus.take_action),    64'(0));
        cycle();

        // Fill and overflow the queue, then drain
        ready_mode = 0;
        for (int s = 0; s < 5; s++) full_scan({$urandom, $urandom});
        check("ovf_level", 64'(bus.fifo_level), 64'(4));
        check("ovf_set",   64'(bus.ovf_flag),   64'(1));
        ready_mode = 1;
        repeat (4) cycle();
        check("drained", 64'(bus.fifo_level), 64'(0));
        capture();
        check("ovf_cleared", 64'(bus.ovf_flag), 64'(0));
        shift_bits(64'(0), DR_W, 1'b0, tv);
        check("ovf_readback", 64'(tv[37]), 64'(1));

        // Short scan
        capture();
        shift_bits({$urandom, $urandom}, 20, 1'b0, tv);
        update();
        check("short_set",   64'(bus.short_flag), 64'(1));
        check("short_level", 64'(bus.fifo_level), 64'(0));
        update();   // update outside a scan is ignored
        check("idle_udr_level", 64'(bus.fifo_level), 64'(0));

        // Reset with queued entries
        ready_mode = 0;
        full_scan({$urandom, $urandom});
        full_scan({$urandom, $urandom});
        check("preq_level", 64'(bus.fifo_level), 64'(2));
        ready_mode = 1;
        reset = 1'b1;
        cycle();
        check("rst_level", 64'(bus.fifo_level), 64'(0));
        check("rst_jdo",   64'(bus.jdo),        64'(0));
        check("rst_pulse", 64'(bus.take_action | bus.take_no_action), 64'(0));
        reset = 1'b0;
        cycle();
        check("rst_after_pulse", 64'(bus.take_action | bus.take_no_action), 64'(0));

        // Randomized scans
        ready_mode = 2;
        for (int it = 0; it < 80; it++) begin
            for (int k = 0; k < N_CH; k++) rd[k] = $urandom;
            if ($urandom_range(0, 3) == 0) set_ir(IR_W'($urandom_range(0, N_CH - 1)));
            capture();
            case ($urandom_range(0, 5))
                0:       n = $urandom_range(1, DR_W - 1);
                1:       n = DR_W + $urandom_range(1, 3);
                default: n = DR_W;
            endcase
            data = {$urandom, $urandom};
            shift_bits(data, n, 1'b1, tv);
            if ($urandom_range(0, 7) == 0) begin
                bus.vs_udr = 1'b1; bus.vs_sdr = 1'b1; bus.shift_en = 1'b1;
                bus.tdi = 1'($urandom_range(0, 1));
                cycle();
                bus.vs_sdr = 1'b0; bus.shift_en = 1'b0; bus.tdi = 1'b0;
                bus.vs_udr = 1'b0;
            end
            if ($urandom_range(0, 7) != 0) update();
            if ($urandom_range(0, 5) == 0) begin
                bus.vs_cdr = 1'b1; bus.vs_udr = 1'b1;
                cycle();
                bus.vs_cdr = 1'b0; bus.vs_udr = 1'b0;
            end
            repeat ($urandom_range(0, 3)) cycle();
            if ($urandom_range(0, 9) == 0) update();
        end
        ready_mode = 1;
        repeat (FIFO_DEPTH + 2) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/debug_slave_scan_engine.md
Name: debug_slave_scan_engine

Overview:
Single-clock debug-slave scan engine, the parametrised successor to the Nios II debug slave's two-domain capture/decode pair. It consumes virtual-JTAG state strobes and serial data already synchronised into clk, and maintains an N-channel instruction register and a DR_W-bit shift register. Completed scans are queued in a command FIFO and drained as one-hot take_action/take_no_action pulses with the scanned payload on jdo. Channel count, payload width, readback width and queue depth are generalised; queueing, short-scan detection and overflow flags are new.

Parameters:
IR_W, 2, instruction register width; number of channels N_CH = 2**IR_W.
DR_W, 38, data register / jdo width; bit DR_W-1 is the action bit. Must satisfy DR_W >= RD_W+2.
RD_W, 32, per-channel readback width.
FIFO_DEPTH, 4, command queue entries; power of 2, >= 2.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vs_uir  in  1  update-IR strobe, one cycle
vs_cdr  in  1  capture-DR strobe, one cycle
vs_sdr  in  1  shift-DR state level
vs_udr  in  1  update-DR strobe, one cycle
shift_en  in  1  one-cycle qualifier; shift one bit when vs_sdr&shift_en
tdi  in  1  serial data in
ir_in  in  IR_W  instruction value, sampled on vs_uir
rd_data  in  N_CH*RD_W  readback words; channel k at [k*RD_W +: RD_W]
cmd_ready  in  1  consumer accepts a command this cycle
tdo  out  1  sr[0]
ir_q  out  IR_W  latched instruction
jdo  out  DR_W  payload of the last popped command
jdo_ir  out  IR_W  instruction of the last popped command
take_action  out  N_CH  one-hot, one-cycle pulse, action bit = 1
take_no_action  out  N_CH  one-hot, one-cycle pulse, action bit = 0
fifo_level  out  clog2(FIFO_DEPTH)+1  queued commands
ovf_flag  out  1  sticky: command dropped on full queue
short_flag  out  1  sticky: update with bit count != DR_W

Behaviour:
- Reset: sr, ir_q, jdo, jdo_ir, bit_cnt, FIFO pointers and level = 0; take_action = take_no_action = 0; ovf_flag = short_flag = 0; tdo = 0. A reset mid-scan or mid-drain discards everything; no pulse is emitted in the reset cycle or the cycle after.
- Scan FSM states: IDLE, SHIFT, UPDATE.
- Any state on vs_uir: ir_q <= ir_in, go to IDLE.
- Any state on vs_cdr: sr <= {ovf_flag, short_flag, zero-ext rd_data[ir_q]}; bit_cnt <= 0; ovf_flag and short_flag are cleared (read-to-clear; a set event in the same cycle wins); go to SHIFT.
- SHIFT on vs_sdr&shift_en: sr <= {tdi, sr[DR_W-1:1]}; bit_cnt saturates at DR_W+1.
- Priority within one cycle: vs_uir > vs_cdr > shift > vs_udr.
- On vs_udr in SHIFT, go to UPDATE for one cycle:
  - bit_cnt == DR_W: push {ir_q, sr}.
  - Otherwise set short_flag and push nothing.
  - Queue full: set ovf_flag, drop the command, queue unchanged.
  - Return to IDLE.
- vs_udr in IDLE is ignored: no push, no flag.
- Drain: each cycle with the queue non-empty and cmd_ready = 1, pop one entry. Next cycle: jdo/jdo_ir = entry; exactly one bit [jdo_ir] of take_action (action bit 1) or take_no_action (action bit 0) is high for one cycle. jdo holds until the next pop.
- Throughput and latency:
  - Maximum one pop per cycle; push and pop in the same cycle are both honoured and the level is unchanged.
  - A push into an empty queue is popped no earlier than the following cycle.
  - Minimum vs_udr -> pulse latency is 2 cycles.
- Queue is FIFO-ordered, pointers wrap modulo FIFO_DEPTH. fifo_level = FIFO_DEPTH means full; 0 means empty.
- tdo = sr[0] combinationally from the register.

Test Plan:
- Reset, ir_in=2 + vs_uir, vs_cdr with rd_data[2]=0xDEADBEEF, 38 shifts of tdi=0 -> tdo sequence is EF,BE,AD,DE LSB-first then 0,0; flags read 0.
- Scan 38 bits value 0x2000000123 on ir=1, vs_udr, cmd_ready=1 -> 2 cycles later take_action=4'b0010 for one cycle, jdo=0x2000000123, jdo_ir=1.
- Same scan with bit37=0 on ir=3 -> take_no_action=4'b1000 pulse; take_action stays 0.
- cmd_ready=0, five complete scans -> fifo_level=4, ovf_flag=1. Then cmd_ready=1 -> four pulses on consecutive cycles in push order. Next vs_cdr captures sr[37]=1 and clears ovf_flag.
- 20-bit scan then vs_udr -> no push, short_flag=1, fifo_level unchanged.
- reset asserted with 2 queued entries and cmd_ready=1 -> no pulses, fifo_level=0, jdo=0.
